// File: rtl/eth4to1_pll_rst_ctrl.sv
// eth4to1_pll_rst_ctrl: reset/lock sequencer for the eth4to1 312.5 MHz PLL.
// It holds the PLL in reset, waits for a synchronized lock, and qualifies that
// lock for LOCK_STABLE_CYCLES. Only then does it release the downstream MAC/FIFO
// reset. If lock is lost while running, the PLL is re-sequenced.
// Optional feature macro: ETH4TO1_PLL_RST_CTRL_RETRY_EN. When it is defined,
// WAIT_LOCK retries the PLL reset after TIMEOUT_CYCLES and counts the retries.
// When it is undefined, WAIT_LOCK waits for lock indefinitely and retry_count
// is tied to 0.
module eth4to1_pll_rst_ctrl #(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int TIMEOUT_CYCLES     = 65536,
  parameter int CNT_W              = 24
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       mac_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] retry_count
);

  // One-hot state encoding. Every output is a single-bit decode of this register,
  // so each output changes cleanly on the state edge.
  localparam logic [3:0] ST_PLL_RST   = 4'b0001;
  localparam logic [3:0] ST_WAIT_LOCK = 4'b0010;
  localparam logic [3:0] ST_STABLE    = 4'b0100;
  localparam logic [3:0] ST_RUN       = 4'b1000;

  // Terminal counts. A phase ends on the cycle the counter reaches N-1.
  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             locked_s;
  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_lost_q, lock_lost_d;

`ifdef ETH4TO1_PLL_RST_CTRL_RETRY_EN
  logic             retry_inc;
  logic [7:0]       retry_q;
`else
  logic             timeout_unused;
  assign timeout_unused = ^TIMEOUT_LAST;
`endif

  assign locked_s = sync_q[1];

  // Two-flop synchronizer for the asynchronous PLL lock signal.
  always_ff @(posedge refclk) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], pll_locked};
  end

  // Next-state logic. The shared counter advances while the state holds
  // and clears on every state change.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    lock_lost_d = lock_lost_q;
`ifdef ETH4TO1_PLL_RST_CTRL_RETRY_EN
    retry_inc   = 1'b0;
`endif
    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == PLL_RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock wins over a timeout that lands on the same cycle.
        if (locked_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
`ifdef ETH4TO1_PLL_RST_CTRL_RETRY_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = ST_PLL_RST;
          cnt_d     = '0;
          retry_inc = 1'b1;
        end
`else
        else begin
          // No timeout here: hold the counter so it cannot wrap while waiting.
          cnt_d = '0;
        end
`endif
      end
      ST_STABLE: begin
        // A lock drop sends us back to WAIT_LOCK with a fresh timeout window.
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d     = ST_PLL_RST;
          lock_lost_d = 1'b1;
        end
      end
      default: begin
        // Recovery path if the one-hot register ever holds an illegal value.
        state_d = ST_PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and sticky lock-loss flag. Reset overrides every transition.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_lost_q <= lock_lost_d;
    end
  end

`ifdef ETH4TO1_PLL_RST_CTRL_RETRY_EN
  // Saturating count of timeout retries. It updates on the same edge as the retry transition.
  always_ff @(posedge refclk) begin
    if (rst)                             retry_q <= 8'd0;
    else if (retry_inc && retry_q != 8'hFF) retry_q <= retry_q + 8'd1;
  end
  assign retry_count = retry_q;
`else
  assign retry_count = 8'd0;
`endif

  assign pll_rst   = state_q[0];
  assign mac_rst   = ~state_q[3];
  assign ready     = state_q[3];
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_eth4to1_pll_rst_ctrl.sv
// Directed bench for eth4to1_pll_rst_ctrl. It runs with PLL_RST=4, STABLE=8 and TIMEOUT=32.
// Expected outputs are packed as {pll_rst, mac_rst, ready, lock_lost, retry_count[7:0]}.
// Edge n is the nth refclk edge that samples rst=0. Each value is checked 1 time unit after its edge.
module tb_eth4to1_pll_rst_ctrl;
  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst, mac_rst, ready, lock_lost;
  logic [7:0] retry_count;
  logic [11:0] obs;
  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  always #5 refclk = ~refclk;

  eth4to1_pll_rst_ctrl #(
    .PLL_RST_CYCLES(4), .LOCK_STABLE_CYCLES(8), .TIMEOUT_CYCLES(32), .CNT_W(24)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .mac_rst(mac_rst), .ready(ready), .lock_lost(lock_lost), .retry_count(retry_count)
  );

  assign obs = {pll_rst, mac_rst, ready, lock_lost, retry_count};

  task automatic step();
    @(posedge refclk);
    #1;
    edge_n++;
  endtask

  task automatic step_to(input int k);
    while (edge_n < k) step();
  endtask

  task automatic start_seq(input logic lock);
    rst = 1'b1;
    pll_locked = lock;
    repeat (3) @(posedge refclk);
    #1;
    rst = 1'b0;
    edge_n = 0;
  endtask

  task automatic test_reset();
    logic [11:0] want;
    rst = 1'b1;
    pll_locked = 1'b1;
    repeat (3) @(posedge refclk);
    #1;
    want = {1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL reset_values: got %b want %b", obs, want); end
  endtask

  task automatic test_clean_start();
    logic [11:0] want;
    start_seq(1'b1);
    step_to(3);
    want = {1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL clean_e3: got %b want %b", obs, want); end
    step_to(4);
    want = {1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL clean_e4: got %b want %b", obs, want); end
    step_to(12);
    checks++;
    if (obs !== want) begin errors++; $display("FAIL clean_e12: got %b want %b", obs, want); end
    step_to(13);
    want = {1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL clean_e13: got %b want %b", obs, want); end
  endtask

  // This test continues from test_clean_start, where RUN is reached at edge 13.
  task automatic test_lock_loss();
    logic [11:0] want;
    step_to(19);
    pll_locked = 1'b0;
    step_to(21);
    want = {1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL loss_e21: got %b want %b", obs, want); end
    step_to(22);
    want = {1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL loss_e22: got %b want %b", obs, want); end
    pll_locked = 1'b1;
    step_to(25);
    checks++;
    if (obs !== want) begin errors++; $display("FAIL loss_e25: got %b want %b", obs, want); end
    step_to(26);
    want = {1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL loss_e26: got %b want %b", obs, want); end
    step_to(34);
    checks++;
    if (obs !== want) begin errors++; $display("FAIL loss_e34: got %b want %b", obs, want); end
    step_to(35);
    want = {1'b0, 1'b0, 1'b1, 1'b1, 8'd0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL loss_e35: got %b want %b", obs, want); end
  endtask

  // This test continues from test_lock_loss (RUN, lock_lost=1). It forces another
  // lock loss, then resets while the controller is in STABLE.
  task automatic test_mid_reset();
    logic [11:0] want;
    pll_locked = 1'b0;
    step_to(38);
    want = {1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL mid_e38: got %b want %b", obs, want); end
    pll_locked = 1'b1;
    step_to(45);
    want = {1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL mid_e45_stable: got %b want %b", obs, want); end
    rst = 1'b1;
    step_to(46);
    want = {1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL mid_rst_edge: got %b want %b", obs, want); end
    rst = 1'b0;
    edge_n = 0;
    step_to(3);
    checks++;
    if (obs !== want) begin errors++; $display("FAIL mid_restart_e3: got %b want %b", obs, want); end
    step_to(4);
    want = {1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL mid_restart_e4: got %b want %b", obs, want); end
    step_to(12);
    checks++;
    if (obs !== want) begin errors++; $display("FAIL mid_restart_e12: got %b want %b", obs, want); end
    step_to(13);
    want = {1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL mid_restart_e13: got %b want %b", obs, want); end
  endtask

  // Lock enters STABLE at edge 7. Lock drops so that locked_s=0 at edge 12,
  // which is the 5th stable cycle. STABLE is re-entered at edge 13, and RUN is reached at edge 21.
  task automatic test_glitch();
    logic [11:0] want;
    start_seq(1'b0);
    step_to(4);
    pll_locked = 1'b1;
    step_to(9);
    pll_locked = 1'b0;
    step_to(10);
    pll_locked = 1'b1;
    step_to(12);
    want = {1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL glitch_e12: got %b want %b", obs, want); end
    step_to(15);
    checks++;
    if (obs !== want) begin errors++; $display("FAIL glitch_e15: got %b want %b", obs, want); end
    step_to(20);
    checks++;
    if (obs !== want) begin errors++; $display("FAIL glitch_e20: got %b want %b", obs, want); end
    step_to(21);
    want = {1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL glitch_e21: got %b want %b", obs, want); end
  endtask

`ifdef ETH4TO1_PLL_RST_CTRL_RETRY_EN
  task automatic test_timeout();
    logic [11:0] want;
    start_seq(1'b0);
    step_to(4);
    want = {1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL tmo_e4: got %b want %b", obs, want); end
    step_to(35);
    checks++;
    if (obs !== want) begin errors++; $display("FAIL tmo_e35: got %b want %b", obs, want); end
    step_to(36);
    want = {1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL tmo_e36: got %b want %b", obs, want); end
    step_to(39);
    checks++;
    if (obs !== want) begin errors++; $display("FAIL tmo_e39: got %b want %b", obs, want); end
    step_to(40);
    want = {1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL tmo_e40: got %b want %b", obs, want); end
    step_to(71);
    checks++;
    if (obs !== want) begin errors++; $display("FAIL tmo_e71: got %b want %b", obs, want); end
    step_to(72);
    want = {1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL tmo_e72: got %b want %b", obs, want); end
  endtask

  // This test continues from test_timeout. Each retry period is 36 edges.
  task automatic test_saturate();
    logic [11:0] want;
    step_to(36 * 254);
    want = {1'b1, 1'b1, 1'b0, 1'b0, 8'd254};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL sat_254: got %b want %b", obs, want); end
    step_to(36 * 255);
    want = {1'b1, 1'b1, 1'b0, 1'b0, 8'd255};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL sat_255: got %b want %b", obs, want); end
    step_to(36 * 300);
    checks++;
    if (obs !== want) begin errors++; $display("FAIL sat_300: got %b want %b", obs, want); end
  endtask

  // locked_s is 1 at edge 36, the same cycle as the timeout. Lock must win.
  task automatic test_lock_vs_timeout();
    logic [11:0] want;
    start_seq(1'b0);
    step_to(33);
    pll_locked = 1'b1;
    step_to(36);
    want = {1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL prio_e36: got %b want %b", obs, want); end
    step_to(43);
    checks++;
    if (obs !== want) begin errors++; $display("FAIL prio_e43: got %b want %b", obs, want); end
    step_to(44);
    want = {1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL prio_e44: got %b want %b", obs, want); end
  endtask
`else
  task automatic test_no_retry();
    logic [11:0] want;
    start_seq(1'b0);
    step_to(4);
    want = {1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL noretry_e4: got %b want %b", obs, want); end
    step_to(36);
    checks++;
    if (obs !== want) begin errors++; $display("FAIL noretry_e36: got %b want %b", obs, want); end
    step_to(500);
    checks++;
    if (obs !== want) begin errors++; $display("FAIL noretry_e500: got %b want %b", obs, want); end
    pll_locked = 1'b1;
    step_to(510);
    checks++;
    if (obs !== want) begin errors++; $display("FAIL noretry_e510: got %b want %b", obs, want); end
    step_to(511);
    want = {1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL noretry_e511: got %b want %b", obs, want); end
  endtask
`endif

  initial begin
    test_reset();
    $display("test_reset done: errors=%0d", errors);
    test_clean_start();
    $display("test_clean_start done: errors=%0d", errors);
    test_lock_loss();
    $display("test_lock_loss done: errors=%0d", errors);
    test_mid_reset();
    $display("test_mid_reset done: errors=%0d", errors);
    test_glitch();
    $display("test_glitch done: errors=%0d", errors);
`ifdef ETH4TO1_PLL_RST_CTRL_RETRY_EN
    test_timeout();
    $display("test_timeout done: errors=%0d", errors);
    test_saturate();
    $display("test_saturate done: errors=%0d", errors);
    test_lock_vs_timeout();
    $display("test_lock_vs_timeout done: errors=%0d", errors);
`else
    test_no_retry();
    $display("test_no_retry done: errors=%0d", errors);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
